// File: rtl/processor_arm_core.sv
// Single-cycle LEGv8 subset core (LDUR/STUR/ADD/SUB/AND/ORR/CBZ).
// Every instruction fetches, executes and retires on one rising edge of CLOCK_50.
module processor_arm_core #(
  parameter int N = 64,
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64,
  parameter logic [IMEM_WORDS*32-1:0] ROM_IMAGE = '0
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         dump,
  output logic [N-1:0] DM_writeData,
  output logic [N-1:0] DM_addr,
  output logic         DM_writeEnable
);
  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  logic [N-1:0]  pc_q, pc_d;
  logic [N-1:0]  regs_q [32];
  logic [N-1:0]  dmem_q [DMEM_WORDS];
  logic [31:0]   rom [IMEM_WORDS];
  logic [31:0]   instr;

  logic          reg2_loc, alu_src, mem_write, reg_write, mem_to_reg, branch;
  logic [3:0]    alu_op;
  logic [4:0]    rn, rm_sel, rd;
  logic [N-1:0]  rd1, rd2, alu_b, alu_result, d_imm, cb_imm, dm_rdata, wb_data;
  logic          zero;
  logic [DA-1:0] dm_idx;

  for (genvar gi = 0; gi < IMEM_WORDS; gi++) begin : g_rom
    assign rom[gi] = ROM_IMAGE[gi*32 +: 32];
  end

  assign instr = rom[pc_q[IA+1:2]];

  // Main control; CBZ is recognised by its 8-bit opcode before the 11-bit decode.
  always_comb begin
    reg2_loc   = 1'b0;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    alu_op     = ALU_ADD;
    if (instr[31:24] == OP_CBZ) begin
      reg2_loc = 1'b1;
      branch   = 1'b1;
      alu_op   = ALU_PASSB;
    end else begin
      case (instr[31:21])
        OP_LDUR: begin alu_src = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; end
        OP_STUR: begin alu_src = 1'b1; reg2_loc = 1'b1; mem_write = 1'b1; end
        OP_ADD:  reg_write = 1'b1;
        OP_SUB:  begin reg_write = 1'b1; alu_op = ALU_SUB; end
        OP_AND:  begin reg_write = 1'b1; alu_op = ALU_AND; end
        OP_ORR:  begin reg_write = 1'b1; alu_op = ALU_ORR; end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd     = instr[4:0];
    rn     = instr[9:5];
    rm_sel = reg2_loc ? instr[4:0] : instr[20:16];
    rd1    = (rn == 5'd31) ? '0 : regs_q[rn];
    rd2    = (rm_sel == 5'd31) ? '0 : regs_q[rm_sel];
    d_imm  = {{(N-9){instr[20]}}, instr[20:12]};
    cb_imm = {{(N-19){instr[23]}}, instr[23:5]};
    alu_b  = alu_src ? d_imm : rd2;
    case (alu_op)
      ALU_AND:   alu_result = rd1 & alu_b;
      ALU_ORR:   alu_result = rd1 | alu_b;
      ALU_ADD:   alu_result = rd1 + alu_b;
      ALU_SUB:   alu_result = rd1 - alu_b;
      ALU_PASSB: alu_result = alu_b;
      default:   alu_result = '0;
    endcase
    zero     = (alu_result == '0);
    dm_idx   = alu_result[DA+2:3];
    dm_rdata = dmem_q[dm_idx];
    wb_data  = mem_to_reg ? dm_rdata : alu_result;
    pc_d     = (branch && zero) ? pc_q + (cb_imm << 2) : pc_q + N'(4);
  end

  assign DM_addr        = alu_result;
  assign DM_writeData   = rd2;
  assign DM_writeEnable = mem_write & reset;

  // dump is consumed by the simulation environment only; shift-amount bits are ignored.
  logic unused_ok;
  assign unused_ok = ^{dump, instr[11:10]};

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
      for (int i = 0; i < 31; i++) regs_q[i] <= N'(i);
      regs_q[31] <= '0;
      for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (reg_write && rd != 5'd31) regs_q[rd] <= wb_data;
      if (mem_write) dmem_q[dm_idx] <= rd2;
    end
  end
endmodule

// File: tb/tb_processor_arm_core.sv
// Bench for processor_arm_core: fixed program, ISA-level reference interpreter,
// randomized run lengths and asynchronous reset pulses.
module tb_processor_arm_core;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;

  function automatic logic [31:0] enc_r(logic [10:0] op, int rm, int rn, int rd);
    return {op, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
  endfunction

  function automatic logic [31:0] enc_d(logic [10:0] op, int imm, int rn, int rt);
    return {op, 9'(imm), 2'b00, 5'(rn), 5'(rt)};
  endfunction

  function automatic logic [31:0] enc_cb(int imm, int rt);
    return {OP_CBZ, 19'(imm), 5'(rt)};
  endfunction

  function automatic logic [31:0] prog_word(int i);
    case (i)
      0:  return enc_d(OP_STUR, 0, 0, 1);
      1:  return enc_r(OP_ADD, 2, 1, 3);
      2:  return enc_d(OP_STUR, 8, 0, 3);
      3:  return enc_r(OP_SUB, 2, 1, 4);
      4:  return enc_d(OP_STUR, 32, 0, 4);
      5:  return enc_r(OP_AND, 2, 3, 5);
      6:  return enc_d(OP_STUR, 40, 0, 5);
      7:  return enc_r(OP_ORR, 2, 1, 6);
      8:  return enc_d(OP_STUR, 48, 0, 6);
      9:  return enc_d(OP_LDUR, 8, 0, 7);
      10: return enc_d(OP_STUR, 16, 0, 7);
      11: return enc_cb(2, 31);
      12: return enc_d(OP_STUR, 56, 0, 1);
      13: return enc_cb(2, 1);
      14: return enc_r(OP_ADD, 2, 1, 31);
      15: return enc_d(OP_STUR, 24, 0, 31);
      16: return enc_r(OP_ADD, 11, 10, 10);
      17: return enc_r(OP_SUB, 4, 11, 11);
      18: return enc_d(OP_STUR, 8, 10, 10);
      19: return enc_d(OP_LDUR, -8, 11, 12);
      20: return enc_r(OP_ORR, 10, 12, 13);
      21: return enc_d(OP_STUR, 0, 12, 13);
      22: return enc_cb(-6, 31);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [64*32-1:0] build_image();
    logic [64*32-1:0] img;
    img = '0;
    for (int i = 0; i < 64; i++) img[i*32 +: 32] = prog_word(i);
    return img;
  endfunction

  localparam logic [64*32-1:0] PROG = build_image();

  logic        clk = 1'b0;
  logic        reset;
  logic        dump;
  logic [63:0] DM_writeData, DM_addr;
  logic        DM_writeEnable;
  int          n_tests = 0;
  int          n_fail = 0;

  processor_arm_core #(.N(64), .IMEM_WORDS(64), .DMEM_WORDS(64), .ROM_IMAGE(PROG)) dut (
    .CLOCK_50(clk), .reset(reset), .dump(dump),
    .DM_writeData(DM_writeData), .DM_addr(DM_addr), .DM_writeEnable(DM_writeEnable)
  );

  always #10 clk = ~clk;

  always @(posedge dump) begin
    for (int i = 0; i < 64; i++) $display("[TB] dump DM[%0d] = %h", i, dut.dmem_q[i]);
  end

  // Architectural reference state.
  logic [63:0] m_pc;
  logic [63:0] m_x [32];
  logic [63:0] m_dm [64];

  typedef struct packed {
    logic        we;
    logic        chk_addr;
    logic        chk_data;
    logic [63:0] addr;
    logic [63:0] data;
  } exp_t;

  task automatic model_reset();
    m_pc = '0;
    for (int i = 0; i < 32; i++) m_x[i] = (i == 31) ? 64'd0 : 64'(i);
    for (int i = 0; i < 64; i++) m_dm[i] = '0;
  endtask

  function automatic logic [63:0] rx(logic [4:0] r);
    return (r == 5'd31) ? 64'd0 : m_x[r];
  endfunction

  function automatic logic [63:0] arith(logic [10:0] op, logic [63:0] a, logic [63:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic exp_t model_expect();
    logic [31:0] ins;
    logic [63:0] imm9;
    exp_t e;
    ins  = prog_word(int'(m_pc[7:2]));
    imm9 = {{55{ins[20]}}, ins[20:12]};
    e = '0;
    if (ins[31:24] == OP_CBZ) begin
      e.chk_addr = 1'b1; e.chk_data = 1'b1;
      e.addr = rx(ins[4:0]); e.data = rx(ins[4:0]);
    end else begin
      case (ins[31:21])
        OP_STUR: begin
          e.we = 1'b1; e.chk_addr = 1'b1; e.chk_data = 1'b1;
          e.addr = rx(ins[9:5]) + imm9; e.data = rx(ins[4:0]);
        end
        OP_LDUR: begin e.chk_addr = 1'b1; e.addr = rx(ins[9:5]) + imm9; end
        OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
          e.chk_addr = 1'b1; e.chk_data = 1'b1;
          e.addr = arith(ins[31:21], rx(ins[9:5]), rx(ins[20:16]));
          e.data = rx(ins[20:16]);
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic model_step();
    logic [31:0] ins;
    logic [63:0] imm9, imm19, a;
    ins   = prog_word(int'(m_pc[7:2]));
    imm9  = {{55{ins[20]}}, ins[20:12]};
    imm19 = {{45{ins[23]}}, ins[23:5]};
    if (ins[31:24] == OP_CBZ) begin
      m_pc = (rx(ins[4:0]) == 0) ? m_pc + (imm19 << 2) : m_pc + 64'd4;
    end else begin
      a = rx(ins[9:5]) + imm9;
      case (ins[31:21])
        OP_LDUR: if (ins[4:0] != 5'd31) m_x[ins[4:0]] = m_dm[a[8:3]];
        OP_STUR: m_dm[a[8:3]] = rx(ins[4:0]);
        OP_ADD, OP_SUB, OP_AND, OP_ORR:
          if (ins[4:0] != 5'd31) m_x[ins[4:0]] = arith(ins[31:21], rx(ins[9:5]), rx(ins[20:16]));
        default: ;
      endcase
      m_pc = m_pc + 64'd4;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      n_tests++; if (DM_writeEnable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", DM_writeEnable); end
      n_tests++; if (DM_addr !== 64'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", DM_addr); end
      n_tests++; if (DM_writeData !== 64'd1) begin n_fail++; $display("FAIL reset_data: got %h want 1", DM_writeData); end
    end
    reset = 1'b1;
    #1;
    n_tests++; if (DM_writeEnable !== 1'b1) begin n_fail++; $display("FAIL release_we: got %0b want 1", DM_writeEnable); end
    n_tests++; if (DM_addr !== 64'd0) begin n_fail++; $display("FAIL release_addr: got %h want 0", DM_addr); end
    n_tests++; if (DM_writeData !== 64'd1) begin n_fail++; $display("FAIL release_data: got %h want 1", DM_writeData); end
    @(posedge clk);
    model_step();
    #1;
    n_tests++; if (dut.dmem_q[0] !== 64'd1) begin n_fail++; $display("FAIL first_store: DM[0] got %h want 1", dut.dmem_q[0]); end
  endtask

  // Hand-derived outputs for the straight-line prologue (X1=1, X2=2).
  task automatic test_program();
    logic        ew [15];
    logic [63:0] ea [15];
    logic [63:0] ed [15];
    ew = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1};
    ea = '{0, 3, 8, '1, 32, 2, 40, 3, 48, 8, 16, 0, 1, 3, 24};
    ed = '{0, 0, 3, 0, '1, 0, 2, 0, 3, 0, 3, 0, 0, 0, 0};
    for (int c = 1; c < 15; c++) begin
      @(negedge clk);
      n_tests++; if (DM_writeEnable !== ew[c]) begin n_fail++; $display("FAIL prog_we[%0d]: got %0b want %0b", c, DM_writeEnable, ew[c]); end
      n_tests++; if (DM_addr !== ea[c]) begin n_fail++; $display("FAIL prog_addr[%0d]: got %h want %h", c, DM_addr, ea[c]); end
      if (ew[c]) begin
        n_tests++; if (DM_writeData !== ed[c]) begin n_fail++; $display("FAIL prog_data[%0d]: got %h want %h", c, DM_writeData, ed[c]); end
        $display("[TB] prologue store addr=%h data=%h", DM_addr, DM_writeData);
      end
      @(posedge clk);
      model_step();
    end
  endtask

  task automatic test_random_run(input int ncyc);
    exp_t e;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      e = model_expect();
      n_tests++; if (DM_writeEnable !== e.we) begin n_fail++; $display("FAIL run_we pc=%h: got %0b want %0b", m_pc, DM_writeEnable, e.we); end
      if (e.chk_addr) begin
        n_tests++; if (DM_addr !== e.addr) begin n_fail++; $display("FAIL run_addr pc=%h: got %h want %h", m_pc, DM_addr, e.addr); end
      end
      if (e.chk_data) begin
        n_tests++; if (DM_writeData !== e.data) begin n_fail++; $display("FAIL run_data pc=%h: got %h want %h", m_pc, DM_writeData, e.data); end
      end
      if (e.we) $display("[TB] pc=%h store addr=%h data=%h", m_pc, DM_addr, DM_writeData);
      if ($urandom_range(0, 149) == 0) begin
        #3 reset = 1'b0;
        model_reset();
        #2;
        n_tests++; if (DM_writeEnable !== 1'b0 || DM_addr !== 64'd0) begin n_fail++; $display("FAIL pulse_reset: we=%0b addr=%h want 0/0", DM_writeEnable, DM_addr); end
        reset = 1'b1;
        $display("[TB] async reset pulse");
      end
      @(posedge clk);
      model_step();
    end
  endtask

  task automatic test_dump();
    exp_t e;
    @(negedge clk);
    dump = 1'b1;
    @(posedge clk);
    model_step();
    @(negedge clk);
    dump = 1'b0;
    e = model_expect();
    n_tests++; if (DM_writeEnable !== e.we) begin n_fail++; $display("FAIL dump_we: got %0b want %0b", DM_writeEnable, e.we); end
    n_tests++; if (e.chk_addr && DM_addr !== e.addr) begin n_fail++; $display("FAIL dump_addr: got %h want %h", DM_addr, e.addr); end
    @(posedge clk);
    model_step();
  endtask

  task automatic test_midrun_reset();
    int nz;
    @(negedge clk);
    #4 reset = 1'b0;
    model_reset();
    #1;
    n_tests++; if (DM_writeEnable !== 1'b0) begin n_fail++; $display("FAIL mid_we: got %0b want 0", DM_writeEnable); end
    n_tests++; if (DM_addr !== 64'd0) begin n_fail++; $display("FAIL mid_addr: got %h want 0", DM_addr); end
    n_tests++; if (DM_writeData !== 64'd1) begin n_fail++; $display("FAIL mid_data: got %h want 1", DM_writeData); end
    nz = 0;
    for (int i = 0; i < 64; i++) if (dut.dmem_q[i] !== 64'd0) nz++;
    n_tests++; if (nz != 0) begin n_fail++; $display("FAIL mid_dm_clear: %0d nonzero words want 0", nz); end
    @(posedge clk);
    #1;
    n_tests++; if (DM_addr !== 64'd0 || DM_writeData !== 64'd1) begin n_fail++; $display("FAIL mid_hold: addr=%h data=%h want 0/1", DM_addr, DM_writeData); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++; if (DM_writeEnable !== 1'b1) begin n_fail++; $display("FAIL mid_release_we: got %0b want 1", DM_writeEnable); end
    @(posedge clk);
    model_step();
  endtask

  initial begin
    reset = 1'b1;
    dump  = 1'b0;
    test_reset();
    test_program();
    test_random_run(int'($urandom_range(250, 450)));
    test_dump();
    test_midrun_reset();
    test_random_run(int'($urandom_range(350, 550)));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
